// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : FSM encoding (IDLE / SHIFT / DONE, 2 bits)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_cell.sv
// Single-bit full subtractor: computes X - Y - Bin.
//   X, Y : operand bits
//   Bin  : borrow in
//   D    : difference bit
//   Bout : borrow out (set when X < Y + Bin)
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = X ^ Y ^ Bin;
  assign Bout = (~X & Y) | (~(X ^ Y) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled only in IDLE; a/b captured on that edge
//   busy       : high while bits are processed (SHIFT)
//   done       : one-cycle pulse when diff/borrow_out are updated
//   diff       : a - b mod 2^WIDTH, held between completions
//   borrow_out : 1 iff a < b
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               bor_q, bor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;

  logic cell_d, cell_bout;

  full_subtractor u_cell (
    .X    (a_sh_q[0]),
    .Y    (b_sh_q[0]),
    .Bin  (bor_q),
    .D    (cell_d),
    .Bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result fills from the top so the first (LSB) bit lands in bit 0
        // after WIDTH shifts.
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        bor_d  = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          // Publish straight from the cell so the output updates on the
          // same edge that processes the last bit.
          diff_d  = {cell_d, res_q[WIDTH-1:1]};
          bout_d  = cell_bout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == ST_SHIFT);
  assign done       = (state_q == ST_DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule
